dwc_ddrphy_zcal_sar: RTL and testbench

Successive-approximation controller for impedance and DAC calibration. It sits directly upstream and downstream of the calibration comparator. It selects the comparator input (CalExt/CalInt/CalCmpr VIO), drives the trial codes calDrvPU/calDrvPD/CalDac, and waits for the RC filter to settle. It then samples and majority-votes the comparator outputs and resolves one code bit per step. Results stay on the code outputs as the calibrated values.

---
 rtl/dwc_ddrphy_zcal_pkg.sv | 86 ++++++++
 rtl/dwc_ddrphy_zcal_vote.sv | 44 ++++
 rtl/dwc_ddrphy_zcal_sar.sv | 257 +++++++++++++++++++++++++
 tb/tb_dwc_ddrphy_zcal_sar.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwc_ddrphy_zcal_pkg.sv
// Shared types and constants for the ZCAL successive-approximation controller.
package dwc_ddrphy_zcal_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SYNC   = 3'd3,
      ST_SAMPLE = 3'd4,
      ST_DECIDE = 3'd5,
      ST_GAP    = 3'd6,
      ST_DONE   = 3'd7
   } zcalState_t;

   typedef enum logic [1:0] {
      PH_PU  = 2'd0,
      PH_PD  = 2'd1,
      PH_DAC = 2'd2
   } zcalPhase_t;

   // Result of searching the enable mask for the next phase to run
   typedef struct packed {
      logic       valid;
      zcalPhase_t phase;
   } phaseSel_t;

   localparam int PU_W   = 5;
   localparam int PD_W   = 5;
   localparam int DAC_W  = 8;
   localparam int CODE_W = 8;   // widest code; narrower codes are zero-extended
   localparam int IDX_W  = 3;   // enough to index bit 7

   localparam logic [2:0] VIO_NONE = 3'b000;
   localparam logic [2:0] VIO_EXT  = 3'b001;
   localparam logic [2:0] VIO_INT  = 3'b010;
   localparam logic [2:0] VIO_CMPR = 3'b100;

   // One-hot per phase; doubles as the CalErr bit position of that phase
   function automatic logic [2:0] phaseOneHot(zcalPhase_t ph);
      logic [2:0] oh;
      case (ph)
         PH_PU:   oh = VIO_EXT;
         PH_PD:   oh = VIO_INT;
         PH_DAC:  oh = VIO_CMPR;
         default: oh = VIO_NONE;
      endcase
      return oh;
   endfunction

   // Index of the code MSB for a phase
   function automatic logic [IDX_W-1:0] phaseMsb(zcalPhase_t ph);
      logic [IDX_W-1:0] msb;
      case (ph)
         PH_PU:   msb = IDX_W'(PU_W - 1);
         PH_PD:   msb = IDX_W'(PD_W - 1);
         default: msb = IDX_W'(DAC_W - 1);
      endcase
      return msb;
   endfunction

   // All-ones value of a phase code, zero-extended to CODE_W
   function automatic logic [CODE_W-1:0] phaseMask(zcalPhase_t ph);
      logic [CODE_W-1:0] mask;
      case (ph)
         PH_PU:   mask = CODE_W'((1 << PU_W) - 1);
         PH_PD:   mask = CODE_W'((1 << PD_W) - 1);
         default: mask = CODE_W'((1 << DAC_W) - 1);
      endcase
      return mask;
   endfunction

   // First enabled phase whose index is >= fromIdx (fromIdx 3 finds nothing)
   function automatic phaseSel_t findPhase(logic [2:0] en, logic [1:0] fromIdx);
      phaseSel_t sel;
      sel.valid = 1'b0;
      sel.phase = PH_PU;
      for (int i = 2; i >= 0; i--) begin
         if (en[i] && (i >= int'(fromIdx))) begin
            sel.valid = 1'b1;
            sel.phase = zcalPhase_t'(2'(i));
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/dwc_ddrphy_zcal_vote.sv
// Two-flop synchronizer on the selected comparator bit followed by a
// majority-vote ones counter. VOTE_N must be odd.
module dwc_ddrphy_zcal_vote #(
   parameter int VOTE_N = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic cmpRaw,
   input  logic clear,
   input  logic enable,
   output logic vote
);

   localparam int CNT_W = $clog2(VOTE_N + 1);

   logic             syncMeta;
   logic             syncStable;
   logic [CNT_W-1:0] onesReg;

   // Bring the asynchronous comparator output into the clock domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncMeta   <= 1'b0;
         syncStable <= 1'b0;
      end else begin
         syncMeta   <= cmpRaw;
         syncStable <= syncMeta;
      end
   end

   // Count synchronized ones across the sample window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         onesReg <= '0;
      end else if (clear) begin
         onesReg <= '0;
      end else if (enable) begin
         onesReg <= onesReg + CNT_W'(syncStable);
      end
   end

   assign vote = (onesReg > CNT_W'(VOTE_N / 2));

endmodule

// File: rtl/dwc_ddrphy_zcal_sar.sv
// Successive-approximation calibration controller: walks PU, PD and DAC codes
// bit by bit against the calibration comparator and leaves the results on
// the code outputs.
module dwc_ddrphy_zcal_sar
   import dwc_ddrphy_zcal_pkg::*;
#(
   parameter int SETTLE_W = 12,
   parameter int VOTE_N   = 3
) (
   input  logic                DfiClk,
   input  logic                Reset,
   input  logic                CalStart,
   input  logic [2:0]          csrCalPhaseEn,
   input  logic [SETTLE_W-1:0] csrSettleCycles,
   input  logic                csrCmpInvertCalDrvPu50,
   input  logic                csrCmpInvertCalDrvPd50,
   input  logic                csrCmpInvertCalDac50,
   input  logic [2:0]          CmpOut,
   output logic                CalExt_VIO,
   output logic                CalInt_VIO,
   output logic                CalCmpr_VIO,
   output logic [PU_W-1:0]     calDrvPU,
   output logic [PD_W-1:0]     calDrvPD,
   output logic [DAC_W-1:0]    CalDac,
   output logic                CalBusy,
   output logic                CalDone,
   output logic [2:0]          CalErr
);

   zcalState_t          stateReg, stateNext;
   zcalPhase_t          phaseReg, phaseNext;
   logic [2:0]          enReg, enNext;
   logic [SETTLE_W-1:0] settleReg, settleNext;
   logic [SETTLE_W-1:0] cntReg, cntNext;
   logic [IDX_W-1:0]    bitIdxReg, bitIdxNext;
   logic [PU_W-1:0]     puReg, puNext;
   logic [PD_W-1:0]     pdReg, pdNext;
   logic [DAC_W-1:0]    dacReg, dacNext;
   logic [2:0]          vioReg, vioNext;
   logic [2:0]          errReg, errNext;
   logic                busyReg, busyNext;
   logic                doneReg, doneNext;

   logic                startAcc;
   phaseSel_t           firstSel, nextSel;
   logic [CODE_W-1:0]   curCode, newCode;
   logic [IDX_W-1:0]    msbIdx;
   logic                codeWrite;
   logic                cmpSel, invSel;
   logic                vote, codeHigh;
   logic                voteClear, voteEn;

   assign startAcc = CalStart && ((stateReg == ST_IDLE) || (stateReg == ST_DONE));
   assign firstSel = findPhase(csrCalPhaseEn, 2'd0);
   assign nextSel  = findPhase(enReg, 2'(phaseReg) + 2'd1);
   assign msbIdx   = phaseMsb(phaseReg);
   assign codeHigh = vote ^ invSel;

   // Route the active phase's code, comparator bit and polarity
   always_comb begin
      curCode = {{(CODE_W-DAC_W){1'b0}}, dacReg};
      cmpSel  = CmpOut[2];
      invSel  = csrCmpInvertCalDac50;
      case (phaseReg)
         PH_PU: begin
            curCode = {{(CODE_W-PU_W){1'b0}}, puReg};
            cmpSel  = CmpOut[0];
            invSel  = csrCmpInvertCalDrvPu50;
         end
         PH_PD: begin
            curCode = {{(CODE_W-PD_W){1'b0}}, pdReg};
            cmpSel  = CmpOut[1];
            invSel  = csrCmpInvertCalDrvPd50;
         end
         default: ;
      endcase
   end

   // Counter is cleared while the synchronizer flushes, counts during SAMPLE
   assign voteClear = (stateReg == ST_SYNC);
   assign voteEn    = (stateReg == ST_SAMPLE);

   dwc_ddrphy_zcal_vote #(
      .VOTE_N (VOTE_N)
   ) uVote (
      .clk    (DfiClk),
      .rst    (Reset),
      .cmpRaw (cmpSel),
      .clear  (voteClear),
      .enable (voteEn),
      .vote   (vote)
   );

   // Next-state, code update and status logic
   always_comb begin
      stateNext  = stateReg;
      phaseNext  = phaseReg;
      enNext     = enReg;
      settleNext = settleReg;
      cntNext    = cntReg;
      bitIdxNext = bitIdxReg;
      puNext     = puReg;
      pdNext     = pdReg;
      dacNext    = dacReg;
      vioNext    = vioReg;
      errNext    = errReg;
      busyNext   = busyReg;
      doneNext   = doneReg;
      newCode    = curCode;
      codeWrite  = 1'b0;

      case (stateReg)
         ST_IDLE, ST_DONE: begin
            if (startAcc) begin
               settleNext = (csrSettleCycles == '0) ? SETTLE_W'(1) : csrSettleCycles;
               enNext     = csrCalPhaseEn;
               errNext    = 3'b000;
               doneNext   = 1'b0;
               busyNext   = 1'b1;
               cntNext    = '0;
               if (firstSel.valid) begin
                  stateNext = ST_SELECT;
                  phaseNext = firstSel.phase;
                  vioNext   = phaseOneHot(firstSel.phase);
               end else begin
                  stateNext = ST_DONE;
               end
            end else if (stateReg == ST_DONE) begin
               // Status flags follow DONE one cycle after entry
               busyNext = 1'b0;
               doneNext = 1'b1;
            end
         end

         ST_SELECT: begin
            newCode         = '0;
            newCode[msbIdx] = 1'b1;
            codeWrite       = 1'b1;
            bitIdxNext      = msbIdx;
            cntNext         = '0;
            stateNext       = ST_SETTLE;
         end

         ST_SETTLE: begin
            if (cntReg == (settleReg - SETTLE_W'(1))) begin
               cntNext   = '0;
               stateNext = ST_SYNC;
            end else begin
               cntNext = cntReg + SETTLE_W'(1);
            end
         end

         ST_SYNC: begin
            if (cntReg == SETTLE_W'(1)) begin
               cntNext   = '0;
               stateNext = ST_SAMPLE;
            end else begin
               cntNext = cntReg + SETTLE_W'(1);
            end
         end

         ST_SAMPLE: begin
            if (cntReg == SETTLE_W'(VOTE_N - 1)) begin
               cntNext   = '0;
               stateNext = ST_DECIDE;
            end else begin
               cntNext = cntReg + SETTLE_W'(1);
            end
         end

         ST_DECIDE: begin
            // Comparator says trial is above target: drop this bit
            newCode   = curCode;
            codeWrite = 1'b1;
            cntNext   = '0;
            if (codeHigh) begin
               newCode[bitIdxReg] = 1'b0;
            end
            if (bitIdxReg != '0) begin
               newCode[bitIdxReg - IDX_W'(1)] = 1'b1;
               bitIdxNext = bitIdxReg - IDX_W'(1);
               stateNext  = ST_SETTLE;
            end else begin
               vioNext   = VIO_NONE;
               stateNext = ST_GAP;
            end
         end

         ST_GAP: begin
            if ((curCode == '0) || (curCode == phaseMask(phaseReg))) begin
               errNext = errReg | phaseOneHot(phaseReg);
            end
            if (nextSel.valid) begin
               phaseNext = nextSel.phase;
               vioNext   = phaseOneHot(nextSel.phase);
               stateNext = ST_SELECT;
            end else begin
               stateNext = ST_DONE;
            end
         end

         default: stateNext = ST_IDLE;
      endcase

      if (codeWrite) begin
         case (phaseReg)
            PH_PU:   puNext  = newCode[PU_W-1:0];
            PH_PD:   pdNext  = newCode[PD_W-1:0];
            default: dacNext = newCode[DAC_W-1:0];
         endcase
      end
   end

   // State and datapath registers; reset clears everything mid-sequence too
   always_ff @(posedge DfiClk or posedge Reset) begin
      if (Reset) begin
         stateReg  <= ST_IDLE;
         phaseReg  <= PH_PU;
         enReg     <= 3'b000;
         settleReg <= SETTLE_W'(1);
         cntReg    <= '0;
         bitIdxReg <= '0;
         puReg     <= '0;
         pdReg     <= '0;
         dacReg    <= '0;
         vioReg    <= VIO_NONE;
         errReg    <= 3'b000;
         busyReg   <= 1'b0;
         doneReg   <= 1'b0;
      end else begin
         stateReg  <= stateNext;
         phaseReg  <= phaseNext;
         enReg     <= enNext;
         settleReg <= settleNext;
         cntReg    <= cntNext;
         bitIdxReg <= bitIdxNext;
         puReg     <= puNext;
         pdReg     <= pdNext;
         dacReg    <= dacNext;
         vioReg    <= vioNext;
         errReg    <= errNext;
         busyReg   <= busyNext;
         doneReg   <= doneNext;
      end
   end

   assign CalExt_VIO  = vioReg[0];
   assign CalInt_VIO  = vioReg[1];
   assign CalCmpr_VIO = vioReg[2];
   assign calDrvPU    = puReg;
   assign calDrvPD    = pdReg;
   assign CalDac      = dacReg;
   assign CalBusy     = busyReg;
   assign CalDone     = doneReg;
   assign CalErr      = errReg;

endmodule

// File: tb/tb_dwc_ddrphy_zcal_sar.sv
// Testbench for dwc_ddrphy_zcal_sar: directed vector table, reset-mid-run
// sequence and randomized runs against a behavioural comparator/result model.
module tb_dwc_ddrphy_zcal_sar;

   localparam int SETTLE_W = 12;
   localparam int VOTE_N   = 3;

   logic                DfiClk = 1'b0;
   logic                Reset;
   logic                CalStart;
   logic [2:0]          csrCalPhaseEn;
   logic [SETTLE_W-1:0] csrSettleCycles;
   logic                csrCmpInvertCalDrvPu50;
   logic                csrCmpInvertCalDrvPd50;
   logic                csrCmpInvertCalDac50;
   logic [2:0]          CmpOut = 3'b000;
   logic                CalExt_VIO, CalInt_VIO, CalCmpr_VIO;
   logic [4:0]          calDrvPU, calDrvPD;
   logic [7:0]          CalDac;
   logic                CalBusy, CalDone;
   logic [2:0]          CalErr;

   always #5 DfiClk = ~DfiClk;

   dwc_ddrphy_zcal_sar #(
      .SETTLE_W (SETTLE_W),
      .VOTE_N   (VOTE_N)
   ) dut (
      .DfiClk                 (DfiClk),
      .Reset                  (Reset),
      .CalStart               (CalStart),
      .csrCalPhaseEn          (csrCalPhaseEn),
      .csrSettleCycles        (csrSettleCycles),
      .csrCmpInvertCalDrvPu50 (csrCmpInvertCalDrvPu50),
      .csrCmpInvertCalDrvPd50 (csrCmpInvertCalDrvPd50),
      .csrCmpInvertCalDac50   (csrCmpInvertCalDac50),
      .CmpOut                 (CmpOut),
      .CalExt_VIO             (CalExt_VIO),
      .CalInt_VIO             (CalInt_VIO),
      .CalCmpr_VIO            (CalCmpr_VIO),
      .calDrvPU               (calDrvPU),
      .calDrvPD               (calDrvPD),
      .CalDac                 (CalDac),
      .CalBusy                (CalBusy),
      .CalDone                (CalDone),
      .CalErr                 (CalErr)
   );

   int         checks   = 0;
   int         failures = 0;
   int         tPU = 0, tPD = 0, tDAC = 0;
   logic [2:0] invModel = 3'b000;
   bit         glitchOn = 1'b0;
   int         gPeriod  = 10;
   int         globalCyc = 0;
   logic [2:0] vioSeen  = 3'b000;
   int         multiVio = 0;
   logic [2:0] cmpRaw;

   // Analog comparator model plus VIO monitor, both evaluated mid-cycle
   always @(negedge DfiClk) begin
      cmpRaw[0] = (int'(calDrvPU) > tPU);
      cmpRaw[1] = (int'(calDrvPD) > tPD);
      cmpRaw[2] = (int'(CalDac) > tDAC);
      cmpRaw = cmpRaw ^ invModel;
      if (glitchOn && ((globalCyc % gPeriod) == 3)) cmpRaw = ~cmpRaw;
      CmpOut = cmpRaw;
      globalCyc++;
      vioSeen = vioSeen | {CalCmpr_VIO, CalInt_VIO, CalExt_VIO};
      if ($countones({CalCmpr_VIO, CalInt_VIO, CalExt_VIO}) > 1) multiVio++;
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Largest code of the given width that does not exceed the target
   function automatic int refCode(int target, int width);
      for (int c = (1 << width) - 1; c > 0; c--) begin
         if (c <= target) return c;
      end
      return 0;
   endfunction

   // Edges from the accepting CalStart edge until CalDone is visible
   function automatic int refCycles(logic [2:0] en, int s);
      int sEff;
      int perBit;
      int total;
      int widths[3];
      widths[0] = 5; widths[1] = 5; widths[2] = 8;
      sEff   = (s < 1) ? 1 : s;
      perBit = sEff + 2 + VOTE_N + 1;
      total  = 1;
      for (int p = 0; p < 3; p++) begin
         if (en[p]) total += 1 + widths[p] * perBit + 1;
      end
      return total;
   endfunction

   task automatic pulseReset();
      @(negedge DfiClk);
      Reset = 1'b1;
      @(negedge DfiClk);
      Reset = 1'b0;
   endtask

   task automatic runCase(input logic [2:0] en, input logic [2:0] inv, input int s,
                          input int tpu, input int tpd, input int tdac,
                          input bit glitch, input bit busyPulse,
                          output int cycles, output logic busyAtStart);
      @(negedge DfiClk);
      csrCalPhaseEn          = en;
      csrSettleCycles        = SETTLE_W'(s);
      csrCmpInvertCalDrvPu50 = inv[0];
      csrCmpInvertCalDrvPd50 = inv[1];
      csrCmpInvertCalDac50   = inv[2];
      invModel = inv;
      tPU = tpu; tPD = tpd; tDAC = tdac;
      glitchOn = glitch;
      gPeriod  = ((s < 1) ? 1 : s) + 2 + VOTE_N + 1;
      CalStart = 1'b1;
      @(posedge DfiClk);
      vioSeen  = 3'b000;
      multiVio = 0;
      @(negedge DfiClk);
      CalStart    = 1'b0;
      busyAtStart = CalBusy;
      cycles = 0;
      while (cycles < 5000) begin
         @(posedge DfiClk);
         cycles++;
         @(negedge DfiClk);
         if (CalDone) break;
         CalStart = busyPulse && (cycles == 30);
      end
      CalStart = 1'b0;
      glitchOn = 1'b0;
   endtask

   task automatic runAndCheck(input string tag, input logic [2:0] en, input logic [2:0] inv,
                              input int s, input int tpu, input int tpd, input int tdac,
                              input bit glitch, input bit busyPulse,
                              input int ePU, input int ePD, input int eDAC,
                              input logic [2:0] eErr, input int eCyc);
      int   cycles;
      logic busyAtStart;
      runCase(en, inv, s, tpu, tpd, tdac, glitch, busyPulse && (eCyc > 40), cycles, busyAtStart);
      check({tag, ".busyStart"}, busyAtStart, 1);
      check({tag, ".cycles"}, cycles, eCyc);
      check({tag, ".done"}, CalDone, 1);
      check({tag, ".busyEnd"}, CalBusy, 0);
      check({tag, ".pu"}, calDrvPU, ePU);
      check({tag, ".pd"}, calDrvPD, ePD);
      check({tag, ".dac"}, CalDac, eDAC);
      check({tag, ".err"}, CalErr, eErr);
      check({tag, ".multiVio"}, multiVio, 0);
      check({tag, ".vioSeen"}, vioSeen, en);
      $display("case %s en=%b inv=%b s=%0d pu=%0d pd=%0d dac=%0d err=%b cycles=%0d",
               tag, en, inv, s, calDrvPU, calDrvPD, CalDac, CalErr, cycles);
   endtask

   typedef struct {
      logic [2:0] en;
      logic [2:0] inv;
      int         s;
      int         tpu, tpd, tdac;
      bit         glitch, busyPulse, preReset;
      int         ePU, ePD, eDAC;
      logic [2:0] eErr;
      int         eCyc;
   } vec_t;

   vec_t vecs[8];
   int   prevPU, prevPD, prevDAC;

   initial begin
      Reset = 1'b1;
      CalStart = 1'b0;
      csrCalPhaseEn = 3'b000;
      csrSettleCycles = '0;
      csrCmpInvertCalDrvPu50 = 1'b0;
      csrCmpInvertCalDrvPd50 = 1'b0;
      csrCmpInvertCalDac50   = 1'b0;

      //          en      inv     s  tpu tpd tdac  gl bp rs  ePU ePD eDAC eErr    eCyc
      vecs[0] = '{3'b100, 3'b000, 4, 0,  0,  11,   0, 0, 1,  0,  0,  11,  3'b000, 83};
      vecs[1] = '{3'b111, 3'b000, 4, 12, 10, 11,   0, 0, 0,  12, 10, 11,  3'b000, 187};
      vecs[2] = '{3'b111, 3'b111, 4, 12, 10, 11,   0, 0, 0,  12, 10, 11,  3'b000, 187};
      vecs[3] = '{3'b111, 3'b000, 4, 31, 10, 0,    0, 0, 0,  31, 10, 0,   3'b101, 187};
      vecs[4] = '{3'b111, 3'b000, 4, 12, 10, 11,   1, 1, 0,  12, 10, 11,  3'b000, 187};
      vecs[5] = '{3'b000, 3'b000, 4, 12, 10, 11,   0, 0, 0,  12, 10, 11,  3'b000, 1};
      vecs[6] = '{3'b111, 3'b000, 0, 5,  20, 200,  0, 0, 0,  5,  20, 200, 3'b000, 133};
      vecs[7] = '{3'b010, 3'b000, 2, 5,  0,  200,  0, 0, 0,  5,  0,  200, 3'b010, 43};

      repeat (3) @(posedge DfiClk);
      @(negedge DfiClk);
      check("reset.outputs",
            int'({CalExt_VIO, CalInt_VIO, CalCmpr_VIO, calDrvPU, calDrvPD, CalDac,
                  CalBusy, CalDone, CalErr}), 0);
      Reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].preReset) pulseReset();
         runAndCheck($sformatf("vec%0d", i), vecs[i].en, vecs[i].inv, vecs[i].s,
                     vecs[i].tpu, vecs[i].tpd, vecs[i].tdac,
                     vecs[i].glitch, vecs[i].busyPulse,
                     vecs[i].ePU, vecs[i].ePD, vecs[i].eDAC, vecs[i].eErr, vecs[i].eCyc);
      end

      // Reset asserted asynchronously while the DAC phase is running
      @(negedge DfiClk);
      csrCalPhaseEn = 3'b111;
      csrSettleCycles = SETTLE_W'(4);
      csrCmpInvertCalDrvPu50 = 1'b0;
      csrCmpInvertCalDrvPd50 = 1'b0;
      csrCmpInvertCalDac50   = 1'b0;
      invModel = 3'b000;
      tPU = 12; tPD = 10; tDAC = 11;
      CalStart = 1'b1;
      @(posedge DfiClk);
      @(negedge DfiClk);
      CalStart = 1'b0;
      repeat (150) @(posedge DfiClk);
      #2;
      check("rstmid.busyBefore", CalBusy, 1);
      check("rstmid.cmprBefore", CalCmpr_VIO, 1);
      Reset = 1'b1;
      #1;
      check("rstmid.outputs",
            int'({CalExt_VIO, CalInt_VIO, CalCmpr_VIO, calDrvPU, calDrvPD, CalDac,
                  CalBusy, CalDone, CalErr}), 0);
      $display("case rstmid async reset in DAC phase busy=%0d dac=%0d", CalBusy, CalDac);
      @(negedge DfiClk);
      Reset = 1'b0;
      runAndCheck("rstmid.rerun", 3'b111, 3'b000, 4, 12, 10, 11, 1'b0, 1'b0,
                  12, 10, 11, 3'b000, 187);

      // Randomized runs checked against the behavioural model
      prevPU = 12; prevPD = 10; prevDAC = 11;
      for (int r = 0; r < 8; r++) begin
         logic [2:0] en, inv, eErr;
         int s, tpu, tpd, tdac, ePU, ePD, eDAC;
         bit glitch, busyPulse;
         en   = 3'($urandom_range(1, 7));
         inv  = 3'($urandom_range(0, 7));
         s    = $urandom_range(0, 5);
         tpu  = $urandom_range(0, 31);
         tpd  = $urandom_range(0, 31);
         tdac = $urandom_range(0, 255);
         glitch    = 1'($urandom_range(0, 1));
         busyPulse = 1'($urandom_range(0, 1));
         ePU  = en[0] ? refCode(tpu, 5)  : prevPU;
         ePD  = en[1] ? refCode(tpd, 5)  : prevPD;
         eDAC = en[2] ? refCode(tdac, 8) : prevDAC;
         eErr[0] = en[0] && ((ePU == 0) || (ePU == 31));
         eErr[1] = en[1] && ((ePD == 0) || (ePD == 31));
         eErr[2] = en[2] && ((eDAC == 0) || (eDAC == 255));
         runAndCheck($sformatf("rand%0d", r), en, inv, s, tpu, tpd, tdac, glitch, busyPulse,
                     ePU, ePD, eDAC, eErr, refCycles(en, s));
         prevPU = ePU; prevPD = ePD; prevDAC = eDAC;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
